// File: rtl/tempsens_pkg.sv
// Shared state encoding (exported on state_o) and DAC rail codes for the
// temperature-sensor SAR sequencer.
package tempsens_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRECHARGE  = 3'd1,
    ST_TRANSITION = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_EVALUATE   = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  function automatic logic [31:0] vmax(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // The low rail is code zero whatever the DAC width.
  function automatic logic [31:0] vmin(input int unsigned n);
    return vmax(n) & 32'd0;
  endfunction

endpackage

// File: rtl/tempsens_sync2.sv
// Two-flop synchronizer for the asynchronous delay-cell output; 2-cycle latency.
// No handshake: q follows d two edges later.
module tempsens_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tempsens_sar_ctrl.sv
// SAR sequencer for the delay cell: N_VDAC trials of MEAS_CYCLES+4 cycles, done_o in the cycle result_o updates.
// start_i is taken only in IDLE and abort_i overrides everything; TEMPSENS_AVG_EN averages 2**AVG_LOG2 conversions.
module tempsens_sar_ctrl
  import tempsens_pkg::*;
#(
  parameter int N_VDAC      = 7,
  parameter int MEAS_CYCLES = 4,
  parameter int AVG_LOG2    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              tempdelay_i,
  output logic [N_VDAC-1:0] dac_data_o,
  output logic              dac_en_o,
  output logic              precharge_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_VDAC-1:0] result_o,
  output logic [2:0]        state_o
);

  localparam int PTR_W = $clog2(N_VDAC);
  localparam int CNT_W = $clog2(MEAS_CYCLES + 2);
  localparam logic [N_VDAC-1:0] VMAX_C    = N_VDAC'(vmax(N_VDAC));
  localparam logic [N_VDAC-1:0] VMIN_C    = N_VDAC'(vmin(N_VDAC));
  localparam logic [N_VDAC-1:0] MSB_C     = {1'b1, {(N_VDAC-1){1'b0}}};
  localparam logic [PTR_W-1:0]  PTR_TOP   = PTR_W'(N_VDAC - 1);
  localparam logic [CNT_W-1:0]  MEAS_LAST = CNT_W'(MEAS_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EVAL_LAST = CNT_W'(1);
`ifdef TEMPSENS_AVG_EN
  localparam int N_CONV = 1 << AVG_LOG2;
`else
  localparam int N_CONV = 1;
`endif
  localparam logic [AVG_LOG2:0] CONV_LAST = (AVG_LOG2 + 1)'(N_CONV - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N_VDAC-1:0] trial, trial_nxt, trial_eval;
  logic [N_VDAC-1:0] result_q, result_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [AVG_LOG2:0] conv, conv_nxt;
  logic              sync_q;

  tempsens_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tempdelay_i),
    .q     (sync_q)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    trial_nxt  = trial;
    ptr_nxt    = ptr;
    conv_nxt   = conv;
    trial_eval = trial;
    trial_eval[ptr] = sync_q;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = ST_PRECHARGE;
          trial_nxt = MSB_C;
          ptr_nxt   = PTR_TOP;
          conv_nxt  = '0;
        end
      end
      ST_PRECHARGE:  state_nxt = ST_TRANSITION;
      ST_TRANSITION: state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (cnt == MEAS_LAST) state_nxt = ST_EVALUATE;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      ST_EVALUATE: begin
        // Decide on the second cycle, once the trial level has crossed the synchronizer.
        if (cnt == EVAL_LAST) begin
          trial_nxt = trial_eval;
          if (ptr != '0) begin
            trial_nxt[ptr - 1'b1] = 1'b1;
            ptr_nxt   = ptr - 1'b1;
            state_nxt = ST_PRECHARGE;
          end else if (conv == CONV_LAST) begin
            state_nxt = ST_DONE;
          end else begin
            trial_nxt = MSB_C;
            ptr_nxt   = PTR_TOP;
            conv_nxt  = conv + 1'b1;
            state_nxt = ST_PRECHARGE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_i) state_nxt = ST_IDLE;
  end

`ifdef TEMPSENS_AVG_EN
  localparam int ACC_W = N_VDAC + AVG_LOG2;
  logic [ACC_W-1:0] acc, acc_sum;
  logic             conv_end;

  assign conv_end   = (state == ST_EVALUATE) && (cnt == EVAL_LAST) && (ptr == '0);
  assign acc_sum    = acc + ACC_W'(trial_eval);
  assign result_nxt = acc_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (reset || abort_i || (state == ST_IDLE && start_i)) acc <= '0;
    else if (conv_end)                                    acc <= acc_sum;
  end
`else
  assign result_nxt = trial_eval;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      trial    <= '0;
      ptr      <= '0;
      conv     <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      trial <= trial_nxt;
      ptr   <= ptr_nxt;
      conv  <= conv_nxt;
      if (state_nxt == ST_DONE) result_q <= result_nxt;
    end
  end

  always_comb begin
    dac_data_o    = VMAX_C;
    precharge_n_o = 1'b0;
    case (state)
      ST_TRANSITION: begin
        dac_data_o    = VMIN_C;
        precharge_n_o = 1'b1;
      end
      ST_MEASURE, ST_EVALUATE: begin
        dac_data_o    = trial;
        precharge_n_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign dac_en_o = (state != ST_IDLE);
  assign busy_o   = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign result_o = result_q;
  assign state_o  = state;

endmodule

// File: tb/tb_tempsens_sar_ctrl.sv
// Randomized scoreboard bench for tempsens_sar_ctrl: a threshold cell model drives
// tempdelay_i, expectations are queued at start and checked by a negedge monitor.
module tb_tempsens_sar_ctrl;
  import tempsens_pkg::*;

  localparam int N  = 7;
  localparam int MC = 4;
  localparam int AL = 2;
`ifdef TEMPSENS_AVG_EN
  localparam int NCONV = 1 << AL;
`else
  localparam int NCONV = 1;
`endif
  localparam int CONV_CYC = NCONV * N * (MC + 4);
  localparam int VMAX     = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         tempdelay_i = 1'b0;
  logic [N-1:0] dac_data_o, result_o;
  logic         dac_en_o, precharge_n_o, busy_o, done_o;
  logic [2:0]   state_o;

  typedef struct {
    int res;
    int start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   trial_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   thr_arr[NCONV];
  int   cur_thr = -1;
  int   meas_cnt = 0;
  int   busy_run = 0;
  int   idx;
  logic [2:0] prev_state = 3'd0;

  tempsens_sar_ctrl #(.N_VDAC(N), .MEAS_CYCLES(MC), .AVG_LOG2(AL)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .tempdelay_i   (tempdelay_i),
    .dac_data_o    (dac_data_o),
    .dac_en_o      (dac_en_o),
    .precharge_n_o (precharge_n_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monotonic cell: fires for codes <= threshold (threshold < 0 never fires).
  function automatic int conv_result(input int thr);
    if (thr < 0)    return 0;
    if (thr > VMAX) return VMAX;
    return thr;
  endfunction

  task automatic push_conv(input int t0, input int t1, input int t2, input int t3,
                           input int start_edge);
    int th[4];
    int sum;
    int res;
    int t;
    exp_t e;
    th  = '{t0, t1, t2, t3};
    sum = 0;
    for (int c = 0; c < NCONV; c++) begin
      res = 0;
      for (int b = N - 1; b >= 0; b--) begin
        t = res | (1 << b);
        trial_q.push_back(t);
        if (t <= th[c]) res = t;
      end
      sum += conv_result(th[c]);
    end
    e.res        = sum >> $clog2(NCONV);
    e.start_edge = start_edge;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_o || state_o != 3'd0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for IDLE, state %0d", name, state_o);
    end
  endtask

  task automatic set_thr(input int t0, input int t1, input int t2, input int t3);
    int th[4];
    th = '{t0, t1, t2, t3};
    for (int c = 0; c < NCONV; c++) thr_arr[c] = th[c];
  endtask

  // Returns at the negedge just after the start edge, with the expectation queued.
  task automatic do_start(input int t0, input int t1, input int t2, input int t3);
    wait_idle("pre_start");
    @(negedge clk);
    set_thr(t0, t1, t2, t3);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    push_conv(t0, t1, t2, t3, cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dac"},   dac_data_o, VMAX);
    chk({tag, "_en"},    dac_en_o, 0);
    chk({tag, "_pn"},    precharge_n_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_res"},   result_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
      meas_cnt = 0;
    end else begin
      busy_run = busy_o ? busy_run + 1 : 0;
      if (state_o == ST_PRECHARGE && prev_state == ST_IDLE) meas_cnt = 0;
      if (state_o == ST_MEASURE && prev_state != ST_MEASURE) begin
        idx = meas_cnt / N;
        if (idx >= NCONV) idx = NCONV - 1;
        cur_thr = thr_arr[idx];
        meas_cnt++;
        if (trial_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL trial: unexpected MEASURE with code %0d", dac_data_o);
        end else begin
          chk("trial", dac_data_o, trial_q.pop_front());
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done: unexpected done_o, result %0d", result_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", result_o, mon_e.res);
          chk("done_latency", cyc - mon_e.start_edge, CONV_CYC);
          chk("busy_len", busy_run, CONV_CYC + 1);
        end
      end
    end
    prev_state  = state_o;
    tempdelay_i = precharge_n_o && dac_en_o && (int'(dac_data_o) <= cur_thr);
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e0;
    int th[4];
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Threshold 45, then the rails.
    do_start(45, 45, 45, 45);
    wait_idle("x45");
    chk("idle_en_x45", dac_en_o, 0);
    chk("idle_dac_x45", dac_data_o, VMAX);
    do_start(VMAX, VMAX, VMAX, VMAX);
    wait_idle("always");
    chk("idle_en_always", dac_en_o, 0);
    do_start(-1, -1, -1, -1);
    wait_idle("never");
    chk("idle_en_never", dac_en_o, 0);

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) begin
        t = int'($urandom_range(0, 128));
        th[c] = (t == 128) ? -1 : t;
      end
      do_start(th[0], th[1], th[2], th[3]);
      wait_idle("random");
    end

    // start_i pulsed during MEASURE of bit 3 must be ignored.
    do_start(45, 45, 45, 45);
    repeat (3 * (MC + 4) + 3) @(negedge clk);
    chk("busy_start_state", state_o, ST_MEASURE);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle("busy_start");
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", busy_o, 0);

    // start_i held high: back-to-back conversions with one IDLE cycle between.
    wait_idle("held_pre");
    @(negedge clk);
    set_thr(45, 45, 45, 45);
    start_i = 1'b1;
    @(negedge clk);
    e0 = cyc;
    push_conv(45, 45, 45, 45, e0);
    push_conv(45, 45, 45, 45, e0 + CONV_CYC + 2);
    repeat (CONV_CYC + 1) @(negedge clk);
    chk("held_gap_idle", state_o, ST_IDLE);
    @(negedge clk);
    start_i = 1'b0;
    chk("held_restart", state_o, ST_PRECHARGE);
    wait_idle("held");

    // abort_i in IDLE has no effect.
    abort_i = 1'b1;
    repeat (2) @(negedge clk);
    abort_i = 1'b0;
    chk("abort_idle_state", state_o, ST_IDLE);
    chk("abort_idle_res", result_o, 45);

    // abort_i during bit 4: IDLE next cycle, result kept, no done.
    do_start(100, 100, 100, 100);
    repeat (2 * (MC + 4) + 4) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_state", state_o, ST_IDLE);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    exp_q.delete();
    trial_q.delete();
    repeat (CONV_CYC + 10) @(negedge clk);
    chk("abort_res_kept", result_o, 45);

    // Reset mid-conversion.
    do_start(45, 45, 45, 45);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    exp_q.delete();
    trial_q.delete();
    reset = 1'b0;

    // Differing thresholds per conversion (averaged when enabled).
    do_start(40, 41, 42, 43);
    wait_idle("avg");

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("trial_q_drained", trial_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tempsens_sar_ctrl.md
# tempsens_sar_ctrl

Successive-approximation measurement sequencer for the temperature-dependent delay cell. It drives the cell's DAC, enable and precharge inputs and samples the delay output. It binary-searches the largest DAC code at which the delay output fires within the measurement window. This replaces the linear DAC sweep: on request it converts in N_VDAC bit-trials, raises a one-cycle done pulse and holds the result for the calibration LUT and 7-segment path.

## Interface
- N_VDAC, 7, DAC and result width
- MEAS_CYCLES, 4, cycles in MEASURE per bit-trial (≥1)
- AVG_LOG2, 2, log2 of conversions averaged; used only with TEMPSENS_AVG_EN
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start_i  in  1  conversion request; sampled only in IDLE
- abort_i  in  1  abandon conversion; return to IDLE
- tempdelay_i  in  1  asynchronous delay-cell output
- dac_data_o  out  N_VDAC  DAC code to delay cell
- dac_en_o  out  1  DAC enable
- precharge_n_o  out  1  precharge (0 = precharging)
- busy_o  out  1  conversion in progress
- done_o  out  1  one-cycle pulse when result_o updates
- result_o  out  N_VDAC  last completed result
- state_o  out  3  current state encoding (debug mux)

## Operation
- Reset values: dac_data_o = all-ones (VMAX), dac_en_o = 0, precharge_n_o = 0, busy_o = 0, done_o = 0, result_o = 0, state IDLE. Trial register, bit pointer and synchronizer are cleared.
- tempdelay_i passes through a 2-flop synchronizer. Only the synchronized value is used.
- States: IDLE, PRECHARGE, TRANSITION, MEASURE, EVALUATE, DONE.
- IDLE: dac_en_o = 0, dac_data_o = VMAX, precharge_n_o = 0. When start_i = 1, the block loads trial = MSB-only code, sets bit pointer = N_VDAC-1 and enters PRECHARGE.
- PRECHARGE, 1 cycle: dac_data_o = VMAX, precharge_n_o = 0.
- TRANSITION, 1 cycle: dac_data_o = VMIN (0), precharge_n_o = 1.
- MEASURE, MEAS_CYCLES cycles: dac_data_o = trial, precharge_n_o = 1.
- EVALUATE, 2 cycles (synchronizer latency): dac_data_o = trial, precharge_n_o = 1. On the last cycle the block samples the synchronized delay value s:
  - s = 1: keep the current bit.
  - s = 0: clear the current bit.
  - If bit pointer > 0, set the next lower bit, decrement the pointer and go to PRECHARGE; otherwise go to DONE.
- dac_en_o = 1 in every state except IDLE.
- DONE, 1 cycle: result_o ← trial, done_o = 1, then IDLE.
- busy_o = 1 in every state except IDLE.
- The search assumes monotonic cell behaviour: delay fires for codes ≤ X and does not fire for codes > X. The result is X, or 0 if the delay never fires.
- Boundaries:
  - start_i outside IDLE (including in DONE) is ignored.
  - abort_i has priority over start_i and over all state transitions. The block goes to IDLE on the next edge; result_o is unchanged and no done_o is raised.
  - abort_i in IDLE has no effect.
  - Reset mid-conversion forces all reset values on the next edge.

## Timing
- Bit-trial period: MEAS_CYCLES + 4 cycles.
- start_i is seen at edge k: PRECHARGE begins cycle k+1, DONE (done_o = 1) occurs in cycle k+1+N_VDAC·(MEAS_CYCLES+4), and busy_o falls on the following edge. Defaults give 56 busy cycles before DONE.
- result_o is valid from the DONE cycle and held until the next DONE.
- A new start_i is accepted in the first IDLE cycle after DONE.

## Configuration
- TEMPSENS_AVG_EN defined: each start runs 2**AVG_LOG2 back-to-back conversions with no IDLE between them, each beginning at PRECHARGE with an MSB trial.
  - Trial results are summed in an (N_VDAC+AVG_LOG2)-bit accumulator, cleared on start.
  - The single DONE after the last conversion loads result_o = accumulator >> AVG_LOG2 (truncating).
  - abort_i discards the accumulator.
- Undefined: single conversion per start; AVG_LOG2 is ignored and no accumulator exists.

## Structure
- Shared package tempsens_pkg holds:
  - the state enum (3-bit, used by state_o);
  - VMAX/VMIN constant functions of N_VDAC;
  - the PRECHARGE/TRANSITION/MEASURE/EVALUATE encodings, also used by the debug mux.
- One sub-module: tempsens_sync2, the 2-flop synchronizer for tempdelay_i.

## Test plan
- Threshold model X = 45 (N_VDAC = 7, MEAS_CYCLES = 4):
  - dac_data_o during MEASURE follows the trials 64, 32, 48, 40, 44, 46, 45;
  - result_o = 45;
  - done_o pulses exactly 57 cycles after the start_i edge;
  - busy_o is high for 57 cycles.
- Delay always fires -> result_o = 127. Delay never fires -> result_o = 0. dac_en_o = 0 in IDLE for both.
- Busy-state requests:
  - start_i pulsed during MEASURE of bit 3 -> ignored, single done_o;
  - start_i held high -> conversions back-to-back separated by one IDLE cycle.
- Abort and reset:
  - abort_i asserted during bit 4 -> IDLE next cycle, busy_o = 0, no done_o, result_o keeps previous value 45;
  - reset mid-conversion -> all outputs at reset values on next edge.
- TEMPSENS_AVG_EN, AVG_LOG2 = 2, thresholds 40, 41, 42, 43 across conversions -> one done_o, result_o = 41 (166 >> 2).
